// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle RV32M execute unit: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle, with pipeline stall, flush abort and 1-cycle special cases.
module ex_muldiv_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EX_start_i,
  input  logic [2:0]            EX_funct3_i,
  input  logic [DATA_WIDTH-1:0] EX_operand1_i,
  input  logic [DATA_WIDTH-1:0] EX_operand2_i,
  input  logic                  EX_flush_i,
  output logic                  EX_stall_o,
  output logic [DATA_WIDTH-1:0] EX_muldiv_result_o,
  output logic                  EX_muldiv_done_o,
  output logic                  EX_busy_o
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        funct3;
  logic              sign1, sign2;
  logic [DW-1:0]     opnd;
  logic [2*DW-1:0]   acc;
  logic [DW-1:0]     result;

  logic              load, step, fin, spec;
  logic              op1_signed, op2_signed, neg1, neg2;
  logic [DW-1:0]     mag1, mag2;
  logic              is_div_in, div_zero, div_ovf;
  logic [DW-1:0]     special_result;
  logic [DW:0]       mul_sum;
  logic [2*DW-1:0]   mul_acc;
  logic [DW:0]       trial;
  logic [2*DW-1:0]   div_acc;
  logic [2*DW-1:0]   step_acc;
  logic [2*DW-1:0]   prod_c;
  logic [DW-1:0]     quo_c, rem_c;
  logic [DW-1:0]     final_result;

  // Operand capture: signedness decode, magnitudes and special-case detection
  always_comb begin
    op1_signed = (EX_funct3_i == 3'b001) || (EX_funct3_i == 3'b010) ||
                 (EX_funct3_i == 3'b100) || (EX_funct3_i == 3'b110);
    op2_signed = (EX_funct3_i == 3'b001) || (EX_funct3_i == 3'b100) ||
                 (EX_funct3_i == 3'b110);
    neg1       = op1_signed & EX_operand1_i[DW-1];
    neg2       = op2_signed & EX_operand2_i[DW-1];
    mag1       = neg1 ? (~EX_operand1_i + DW'(1)) : EX_operand1_i;
    mag2       = neg2 ? (~EX_operand2_i + DW'(1)) : EX_operand2_i;
    is_div_in  = EX_funct3_i[2];
    div_zero   = is_div_in && (EX_operand2_i == '0);
    div_ovf    = is_div_in && !EX_funct3_i[0] &&
                 (EX_operand1_i == {1'b1, {(DW-1){1'b0}}}) && (EX_operand2_i == '1);
    if (div_zero) special_result = EX_funct3_i[1] ? EX_operand1_i : '1;
    else          special_result = EX_funct3_i[1] ? '0 : EX_operand1_i;
  end

  // One iteration of each algorithm; acc holds {hi,lo} product or {rem,quo}
  always_comb begin
    mul_sum  = {1'b0, acc[2*DW-1:DW]} + {1'b0, (acc[0] ? opnd : DW'(0))};
    mul_acc  = {mul_sum, acc[DW-1:1]};
    trial    = {acc[2*DW-1:DW], acc[DW-1]};
    if (trial >= {1'b0, opnd}) begin
      div_acc = {DW'(trial - {1'b0, opnd}), acc[DW-2:0], 1'b1};
    end else begin
      div_acc = {trial[DW-1:0], acc[DW-2:0], 1'b0};
    end
    step_acc = funct3[2] ? div_acc : mul_acc;
  end

  // Sign correction and result select on the final iteration
  always_comb begin
    prod_c = (sign1 ^ sign2) ? (~mul_acc + (2*DW)'(1)) : mul_acc;
    quo_c  = (sign1 ^ sign2) ? (~div_acc[DW-1:0] + DW'(1)) : div_acc[DW-1:0];
    rem_c  = sign1 ? (~div_acc[2*DW-1:DW] + DW'(1)) : div_acc[2*DW-1:DW];
    case (funct3)
      3'b000:        final_result = prod_c[DW-1:0];
      3'b100, 3'b101: final_result = quo_c;
      3'b110, 3'b111: final_result = rem_c;
      default:       final_result = prod_c[2*DW-1:DW];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and control strobes
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    fin        = 1'b0;
    spec       = 1'b0;
    case (state)
      IDLE: begin
        if (EX_start_i && !EX_flush_i) begin
          load = 1'b1;
          if (div_zero || div_ovf) begin
            spec       = 1'b1;
            state_next = DONE;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        if (EX_flush_i) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_W'(DW - 1)) begin
            fin        = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      funct3 <= '0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      if (load) begin
        cnt    <= '0;
        funct3 <= EX_funct3_i;
        sign1  <= neg1;
        sign2  <= neg2;
        opnd   <= is_div_in ? mag2 : mag1;
        acc    <= {DW'(0), (is_div_in ? mag1 : mag2)};
      end
      if (spec) result <= special_result;
      if (step) begin
        acc <= step_acc;
        cnt <= cnt + CNT_W'(1);
      end
      if (fin) result <= final_result;
    end
  end

  assign EX_stall_o         = EX_start_i & ~EX_flush_i & (state != DONE);
  assign EX_muldiv_done_o   = (state == DONE) & ~EX_flush_i;
  assign EX_busy_o          = (state != IDLE);
  assign EX_muldiv_result_o = result;

endmodule

// File: doc/ex_muldiv_sequencer.md
EX_MULDIV_SEQUENCER -- requirements
Module: ex_muldiv_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port EX_start_i  input  1  RV32M instruction present in EX (opcode 0110011, funct7 0000001).
REQ-005 SHALL have port EX_funct3_i  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port EX_operand1_i  input  DATA_WIDTH  rs1 after forwarding.
REQ-007 SHALL have port EX_operand2_i  input  DATA_WIDTH  rs2 after forwarding.
REQ-008 SHALL have port EX_flush_i  input  1  EX flush (branch mispredict/trap); aborts any op.
REQ-009 SHALL have port EX_stall_o  output  1  freeze IF/ID/EX pipeline registers.
REQ-010 SHALL have port EX_muldiv_result_o  output  DATA_WIDTH  result, valid while EX_muldiv_done_o=1.
REQ-011 SHALL have port EX_muldiv_done_o  output  1  one-cycle result-valid strobe.
REQ-012 SHALL have port EX_busy_o  output  1  state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE + EX_start_i=1 + EX_flush_i=0 SHALL capture funct3 and operand magnitudes/signs, clear 6-bit iteration counter, go to CALC.
REQ-015 Signedness: MULH/DIV/REM both operands signed; MULHSU operand1 signed, operand2 unsigned; MUL/MULHU/DIVU/REMU unsigned; signed operands converted to magnitude at capture.
REQ-016 CALC SHALL do one iteration per cycle: multiply = radix-2 shift-add into 2*DATA_WIDTH product; divide = restoring shift-subtract, one quotient bit per cycle.
REQ-017 CALC SHALL go to DONE after exactly DATA_WIDTH iterations (counter 0..DATA_WIDTH-1).
REQ-018 Result sign correction SHALL occur on CALC->DONE: product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-019 Result select: MUL = product[DW-1:0]; MULH/MULHSU/MULHU = product[2DW-1:DW]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-020 Divide by zero SHALL go IDLE->DONE directly (1-cycle latency): DIV/DIVU = all ones; REM/REMU = operand1.
REQ-021 Signed overflow (DIV/REM, operand1 = 0x80000000, operand2 = 0xFFFFFFFF) SHALL go IDLE->DONE directly: DIV = 0x80000000; REM = 0.
REQ-022 DONE SHALL assert EX_muldiv_done_o=1 for exactly one cycle, hold the result register, then go to IDLE.
REQ-023 EX_stall_o SHALL be combinational = EX_start_i & ~EX_flush_i & (state != DONE); low in DONE so the op retires that cycle.
REQ-024 Latency from EX_start_i rising in IDLE to done: DATA_WIDTH+1 cycles (33 for DW=32); special cases 1 cycle.
REQ-025 Back-to-back: after DONE->IDLE, a held-high EX_start_i (next M-op) SHALL start a new op with no extra bubble.
REQ-026 EX_flush_i=1 in any state SHALL force IDLE next cycle, suppress done, and discard partial results; flush in DONE suppresses the strobe.
REQ-027 EX_operand1_i/EX_operand2_i/EX_funct3_i changes during CALC SHALL not affect the result.
REQ-028 EX_muldiv_result_o SHALL hold its last value outside DONE.

Reset
REQ-029 rst=1 SHALL immediately (asynchronously) force IDLE, counter 0, result 0, EX_muldiv_done_o=0, EX_busy_o=0; EX_stall_o follows REQ-023.
REQ-030 Reset asserted mid-CALC SHALL abandon the op; no done strobe after release until a new start.

Verification
REQ-031 MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> stall 33 cycles, done at cycle 33, result 0xFFFFFFEB.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 DIVU 5/0 -> done after 1 cycle, 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, 1 cycle.
REQ-035 Start DIV, assert EX_flush_i at CALC cycle 10 -> IDLE next cycle, no done; next start MUL 3x4 -> 12 after 33 cycles.
REQ-036 Assert rst at CALC cycle 5 -> outputs 0 same cycle, busy=0; two back-to-back MUL ops -> two done strobes 34 cycles apart.
